// File: rtl/vga_frame_fetch_pkg.sv
// Shared GPU definitions: bus widths, frame-fetch FSM encoding and framebuffer limits.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

package vga_frame_fetch_pkg;

  localparam int REG_W        = `REG_SIZE;
  localparam int ADDR_W       = `ADDR_SIZE;
  localparam int FB_WORDS_MAX = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

  // Shared-memory address of framebuffer word idx; wraps at the address width.
  function automatic logic [ADDR_W-1:0] fb_addr(input int unsigned base, input logic [7:0] idx);
    return ADDR_W'(base + 32'(idx));
  endfunction

endpackage

// File: rtl/vga_line_buf.sv
// Framebuffer word store: one write port, one registered read port returning 0 past DEPTH.
module vga_line_buf
  import vga_frame_fetch_pkg::*;
#(
  parameter int DEPTH = FB_WORDS_MAX,
  parameter int DW    = REG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [7:0]    rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{wr_addr, rd_addr};

  // Storage is deliberately not reset so a frame survives a fetch abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr[AW-1:0]] <= wr_data;
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < 9'(DEPTH)) rd_data_d = mem_q[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_frame_fetch.sv
// Fetches FB_WORDS framebuffer words from shared memory into a local pixel buffer.
// Define VGA_FETCH_DOUBLE_BUF_EN for front/back buffering swapped on frame_sync.
module vga_frame_fetch
  import vga_frame_fetch_pkg::*;
#(
  parameter int unsigned FB_BASE  = 0,
  parameter int          FB_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  output logic                  mem_rd_req,
  output logic [`ADDR_SIZE-1:0] mem_addr,
  input  logic [`REG_SIZE-1:0]  mem_rd_data,
  input  logic                  mem_ready,
  input  logic [7:0]            pix_addr,
  output logic [`REG_SIZE-1:0]  pix_data,
  input  logic                  frame_sync
);

  localparam logic [7:0] LAST_IDX = 8'(FB_WORDS - 1);

  fetch_state_e              state_q, state_d;
  logic [7:0]                idx_q, idx_d;
  logic                      mem_rd_req_q, mem_rd_req_d;
  logic [`ADDR_SIZE-1:0]     mem_addr_q, mem_addr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      start_ok;
  logic                      wr_en;

  assign wr_en = (state_q == REQ) && mem_ready;

`ifdef VGA_FETCH_DOUBLE_BUF_EN
  logic                      swap_pending_q, swap_pending_d;
  logic                      front_q, front_d;
  logic [1:0]                buf_we;
  logic [1:0][`REG_SIZE-1:0] buf_rd;

  // A finished frame must be shown before the back buffer may be refilled.
  assign start_ok = start && !swap_pending_q;

  always_comb begin
    swap_pending_d = swap_pending_q;
    front_d        = front_q;
    if (state_q == DONE) begin
      swap_pending_d = 1'b1;
    end else if (swap_pending_q && !frame_sync) begin
      swap_pending_d = 1'b0;
      front_d        = ~front_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_pending_q <= 1'b0;
      front_q        <= 1'b0;
    end else begin
      swap_pending_q <= swap_pending_d;
      front_q        <= front_d;
    end
  end

  assign buf_we[0] = wr_en &&  front_q;
  assign buf_we[1] = wr_en && !front_q;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    vga_line_buf #(.DEPTH(FB_WORDS), .DW(`REG_SIZE)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_we[b]),
      .wr_addr (idx_q),
      .wr_data (mem_rd_data),
      .rd_addr (pix_addr),
      .rd_data (buf_rd[b])
    );
  end

  assign pix_data = front_q ? buf_rd[1] : buf_rd[0];
`else
  logic unused_frame_sync;

  assign unused_frame_sync = frame_sync;
  assign start_ok          = start;

  vga_line_buf #(.DEPTH(FB_WORDS), .DW(`REG_SIZE)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (mem_rd_data),
    .rd_addr (pix_addr),
    .rd_data (pix_data)
  );
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_addr_d   = mem_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d      = REQ;
          idx_d        = 8'd0;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = fb_addr(FB_BASE, 8'd0);
          busy_d       = 1'b1;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d      = LAST;
            mem_rd_req_d = 1'b0;
          end else begin
            idx_d      = idx_q + 8'd1;
            mem_addr_d = fb_addr(FB_BASE, idx_q + 8'd1);
          end
        end
      end
      LAST: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd_req = mem_rd_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed self-checking bench for vga_frame_fetch with FB_WORDS=4, FB_BASE=0x10.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module tb_vga_frame_fetch;

  localparam int RW = `REG_SIZE;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  mem_ready = 1'b0;
  logic                  frame_sync = 1'b1;
  logic [7:0]            pix_addr = 8'd0;
  logic [7:0]            gen = 8'd0;
  logic                  done, busy, mem_rd_req;
  logic [`ADDR_SIZE-1:0] mem_addr;
  logic [`REG_SIZE-1:0]  mem_rd_data, pix_data;
  int                    compared = 0;
  int                    mismatched = 0;

  // Source data encodes the fetch generation and the address it came from.
  function automatic logic [31:0] word(input logic [7:0] g, input logic [15:0] a);
    return {g, 8'h5A, a};
  endfunction

  assign mem_rd_data = RW'(word(gen, 16'(mem_addr)));

  vga_frame_fetch #(.FB_BASE(32'h10), .FB_WORDS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (done === 1'b1) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int c;
    int n;
    // Reset values, asynchronously
    #2 reset = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_req", mem_rd_req, 1'b0);
    chkw("rst_addr", 32'(mem_addr), 32'h0);
    chkw("rst_pix", 32'(pix_data), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
`ifdef VGA_FETCH_DOUBLE_BUF_EN
    frame_sync = 1'b0;
`endif

    // Full-rate fetch
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chkw($sformatf("a_addr%0d", k), 32'(mem_addr), 32'(32'h10 + k));
      chk1($sformatf("a_req%0d", k), mem_rd_req, 1'b1);
      chk1($sformatf("a_busy%0d", k), busy, 1'b1);
      tick();
    end
    chk1("a_last_req", mem_rd_req, 1'b0);
    chk1("a_last_busy", busy, 1'b1);
    chk1("a_last_done", done, 1'b0);
    tick();
    chk1("a_done", done, 1'b1);
    chk1("a_done_busy", busy, 1'b0);
    tick();
    chk1("a_done_drop", done, 1'b0);
    chk1("a_idle_busy", busy, 1'b0);
    mem_ready = 1'b0;

    // Pixel readback including out-of-range indices
    pix_addr = 8'd1; tick();
    chkw("b_pix1", 32'(pix_data), word(8'd0, 16'h11));
    pix_addr = 8'd3; tick();
    chkw("b_pix3", 32'(pix_data), word(8'd0, 16'h13));
    pix_addr = 8'd200; tick();
    chkw("b_pix200", 32'(pix_data), 32'h0);
    pix_addr = 8'd4; tick();
    chkw("b_pix4", 32'(pix_data), 32'h0);

    // Three stall cycles per word, with a stray start while busy
    gen = 8'd1;
    start = 1'b1; tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        chkw($sformatf("c_stall_addr%0d_%0d", k, s), 32'(mem_addr), 32'(32'h10 + k));
        chk1($sformatf("c_stall_req%0d_%0d", k, s), mem_rd_req, 1'b1);
        start = (k == 1 && s == 0);
        tick();
      end
      start = 1'b0;
      mem_ready = 1'b1;
      chkw($sformatf("c_addr%0d", k), 32'(mem_addr), 32'(32'h10 + k));
      tick();
    end
    mem_ready = 1'b0;
    count_done(8, c);
    chkw("c_done_count", 32'(c), 32'd1);
    chk1("c_busy_after", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pix_addr = 8'(k); tick();
      chkw($sformatf("c_pix%0d", k), 32'(pix_data), word(8'd1, 16'(16'h10 + k)));
    end

    // Reset while idx=2
    gen = 8'd2;
    mem_ready = 1'b1; start = 1'b1; tick();
    start = 1'b0;
    tick(); tick();
    chkw("d_addr_idx2", 32'(mem_addr), 32'h12);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("d_rst_req", mem_rd_req, 1'b0);
    chkw("d_rst_addr", 32'(mem_addr), 32'h0);
    chk1("d_rst_busy", busy, 1'b0);
    chk1("d_rst_done", done, 1'b0);
    chkw("d_rst_pix", 32'(pix_data), 32'h0);
    tick();
    reset = 1'b1;
    count_done(6, c);
    chkw("d_no_done", 32'(c), 32'd0);
    pix_addr = 8'd3; tick();
    chkw("d_kept_word3", 32'(pix_data), word(8'd1, 16'h13));
    mem_ready = 1'b1; start = 1'b1; tick();
    chkw("d_refetch_addr", 32'(mem_addr), 32'h10);
    chk1("d_refetch_req", mem_rd_req, 1'b1);
    start = 1'b0;
    count_done(10, c);
    chkw("d_refetch_done", 32'(c), 32'd1);
    pix_addr = 8'd2; tick();
    chkw("d_pix2", 32'(pix_data), word(8'd2, 16'h12));

    // start held high through DONE restarts from the following IDLE cycle
    gen = 8'd3;
    start = 1'b1; mem_ready = 1'b1; tick();
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("e_done_seen", done, 1'b1);
    tick();
    chk1("e_idle_busy", busy, 1'b0);
`ifdef VGA_FETCH_DOUBLE_BUF_EN
    tick();
    chk1("e_pending_req", mem_rd_req, 1'b0);
`endif
    tick();
    chk1("e_restart_req", mem_rd_req, 1'b1);
    chkw("e_restart_addr", 32'(mem_addr), 32'h10);
    start = 1'b0;
    count_done(12, c);
    chkw("e_done_count", 32'(c), 32'd1);

`ifdef VGA_FETCH_DOUBLE_BUF_EN
    // Back-buffer fill stays hidden until frame_sync
    frame_sync = 1'b1;
    gen = 8'd4;
    start = 1'b1; tick();
    start = 1'b0;
    count_done(10, c);
    chkw("f_done_count", 32'(c), 32'd1);
    pix_addr = 8'd1; tick(); tick();
    chkw("f_old_pix", 32'(pix_data), word(8'd3, 16'h11));
    start = 1'b1; tick(); tick();
    chk1("f_ign_busy", busy, 1'b0);
    chk1("f_ign_req", mem_rd_req, 1'b0);
    start = 1'b0;
    frame_sync = 1'b0; tick();
    chkw("f_new_pix", 32'(pix_data), word(8'd4, 16'h11));
    frame_sync = 1'b1;
`endif
    mem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
